memory_request_arbiter: RTL
===========================

# memory_request_arbiter

Responder side of the CPU's memory request interface. The control unit and datapath issue `iREN`, `dREN` and `dWEN` with addresses. This block arbitrates those requests onto the single-ported RAM, sequences each access through a small FSM, and returns loaded data with `iwait`/`dwait` handshakes. It sits between the datapath/request unit and the RAM model.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum number of XFER cycles without `ramstate==ACCESS` before the access is aborted with an error; legal range 2..255.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  1  instruction fetch request.
- `iaddr`  in  32  instruction word address.
- `dREN`  in  1  data load request.
- `dWEN`  in  1  data store request.
- `daddr`  in  32  data address.
- `dstore`  in  32  store data.
- `iwait`  out  1  low for exactly one cycle when an instruction fetch completes; high otherwise.
- `iload`  out  32  fetched instruction, registered; holds its value until the next fetch completes.
- `dwait`  out  1  low for exactly one cycle when a data access completes; high otherwise.
- `dload`  out  32  loaded data, registered; holds its value until the next data read completes.
- `ramREN`  out  1  RAM read strobe.
- `ramWEN`  out  1  RAM write strobe.
- `ramaddr`  out  32  RAM address, latched.
- `ramstore`  out  32  RAM write data, latched.
- `ramload`  in  32  RAM read data; valid when `ramstate==ACCESS`.
- `ramstate`  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `mem_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- FSM states are IDLE, XFER and RESP. The latched request kind is one of INSTR, DRD or DWR.
- In IDLE, requests are sampled with priority `dWEN` > `dREN` > `iREN`.
  - The winner's kind, address and (for stores) `dstore` are latched.
  - The next state is XFER.
  - With no request, the FSM stays in IDLE.
- If `dWEN` and `dREN` are both high, the request is treated as DWR and `mem_err` is set.
- If a data request has `daddr[1:0]!=0`, the RAM is not accessed. The next state is RESP with an error; `dload` is unchanged and `mem_err` is set.
- In XFER:
  - `ramREN=1` for INSTR or DRD; `ramWEN=1` for DWR.
  - `ramaddr` and `ramstore` come from the latched registers.
  - The timeout counter increments each cycle in which `ramstate` is not ACCESS.
- XFER exits:
  - `ramstate==ACCESS`: go to RESP. For INSTR, `iload<=ramload`; for DRD, `dload<=ramload`.
  - `ramstate==ERROR`: go to RESP and set `mem_err`. The destination load register is written with 32'hBAD1BAD1 (DWR writes nothing).
  - Counter reaches `TIMEOUT`: behaves the same as ERROR.
  - FREE or BUSY without timeout: stay in XFER.
- In RESP:
  - INSTR drives `iwait=0`; DRD and DWR drive `dwait=0`.
  - The RAM strobes are 0.
  - The next state is always IDLE, and the timeout counter clears.
- Requests are non-abortable. If a requester deasserts its request during XFER, the RAM access still completes and the RESP pulse is still issued.
- Only one transaction is outstanding at a time. Requests are never queued; a losing requester keeps its request held and wins a later IDLE cycle.
- Reset values:
  - state is IDLE and the timeout counter is 0;
  - `iwait=1`, `dwait=1`;
  - `iload`, `dload`, `ramaddr` and `ramstore` are 0;
  - `ramREN=0`, `ramWEN=0`, `mem_err=0`.

## Timing
- A request first seen in IDLE at cycle n puts the FSM in XFER at n+1.
- If `ramstate==ACCESS` at cycle n+1, RESP is at n+2, with the wait line low during n+2 only and load data valid from n+2. Minimum latency is therefore 2 cycles from request to wait low.
- Each RAM cycle not in ACCESS adds one cycle of latency.
- A timeout puts the FSM in RESP at cycle n+1+`TIMEOUT`.
- Back-to-back transactions: RESP→IDLE→XFER, so RAM strobes are low for at least 2 cycles between accesses.
- A misaligned data request is in RESP at cycle n+1.
- Asserting `nRST` mid-transaction immediately forces the reset values, including dropping the RAM strobes asynchronously. No response pulse is produced for the aborted transaction.
- All outputs are registered or decoded from state only. No combinational path exists from any request input to any output.

## Test plan
- Reset, then `iREN=1`, `iaddr=32'h40`, RAM in ACCESS immediately with `ramload=32'h8C220004` → `ramREN` high for 1 cycle; `iwait=0` on cycle 2 only; `iload=32'h8C220004`.
- `iREN`, `dREN` and `dWEN` all asserted together, `daddr=32'h100`, `dstore=32'hDEADBEEF` → write served first (`ramWEN=1`, `ramstore=32'hDEADBEEF`, `dwait` pulses), then `dREN` is served; `iREN` is served only after both data requests are dropped.
- `dREN`, RAM holds BUSY for 3 cycles then ACCESS with 32'h12345678 → `dwait` low at cycle 5; `dload=32'h12345678`; `mem_err=0`.
- RAM stuck BUSY with `TIMEOUT=16` → RESP at cycle 17; `dload=32'hBAD1BAD1`; `mem_err=1` and stays set through further good accesses.
- `dWEN` with `daddr=32'h103` → no `ramWEN`; `dwait` low at cycle 1; `mem_err=1`.
- `nRST` pulsed low during XFER → strobes drop immediately, all outputs at reset values, and the next `iREN` completes normally.

Source files
------------

// File: rtl/memory_request_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_request_arbiter_if
// Brief    : CPU request / RAM handshake bundle around the memory arbiter.
// Revision : 1.0
// ============================================================================
interface memory_request_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        iwait;
    logic [31:0] iload;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );
endinterface
`default_nettype wire

// File: rtl/memory_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_request_arbiter
// Brief    : Arbitrates fetch/load/store requests onto a single-ported RAM.
// Revision : 1.0
// ============================================================================
module memory_request_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  wire logic               CLK,
    input  wire logic               nRST,
    memory_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {INSTR = 2'd0, DRD = 2'd1, DWR = 2'd2} kind_t;

    localparam logic [1:0]  c_RAM_ACCESS   = 2'd2;
    localparam logic [1:0]  c_RAM_ERROR    = 2'd3;
    localparam logic [31:0] c_ERR_WORD     = 32'hBAD1BAD1;
    localparam logic [7:0]  c_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] store_q, store_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        data_req;
    logic        misaligned;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            kind_q  <= INSTR;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        store_d    = store_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        data_req   = bus.dWEN | bus.dREN;
        misaligned = data_req && (bus.daddr[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                if (data_req || bus.iREN) begin
                    cnt_d = '0;
                    if (bus.dWEN) begin
                        kind_d  = DWR;
                        addr_d  = bus.daddr;
                        store_d = bus.dstore;
                    end else if (bus.dREN) begin
                        kind_d = DRD;
                        addr_d = bus.daddr;
                    end else begin
                        kind_d = INSTR;
                        addr_d = bus.iaddr;
                    end
                    // Conflicting load+store or a misaligned data word is a protocol error.
                    if ((bus.dWEN && bus.dREN) || misaligned) begin
                        err_d = 1'b1;
                    end
                    state_d = misaligned ? RESP : XFER;
                end
            end
            XFER: begin
                if (bus.ramstate == c_RAM_ACCESS) begin
                    state_d = RESP;
                    if (kind_q == INSTR) begin
                        iload_d = bus.ramload;
                    end else if (kind_q == DRD) begin
                        dload_d = bus.ramload;
                    end
                end else if ((bus.ramstate == c_RAM_ERROR) || (cnt_q == c_TIMEOUT_LAST)) begin
                    // Timeout fires on the TIMEOUT-th non-ACCESS cycle and is treated as a RAM error.
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (kind_q == INSTR) begin
                        iload_d = c_ERR_WORD;
                    end else if (kind_q == DRD) begin
                        dload_d = c_ERR_WORD;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes and handshakes decode from state only, so reset drops them without a clock.
    assign bus.ramREN   = (state_q == XFER) && (kind_q != DWR);
    assign bus.ramWEN   = (state_q == XFER) && (kind_q == DWR);
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.iwait    = !((state_q == RESP) && (kind_q == INSTR));
    assign bus.dwait    = !((state_q == RESP) && (kind_q != INSTR));
    assign bus.iload    = iload_q;
    assign bus.dload    = dload_q;
    assign bus.mem_err  = err_q;
endmodule
`default_nettype wire
